// File: rtl/rm_pkg.sv
// rtl/rm_pkg.sv - shared types, defaults and helpers for the runtime-monitor verdict path
package rm_pkg;

    localparam int RM_NUM_PROPS    = 4;
    localparam int RM_ACC_PER_PROP = 4;
    localparam int RM_CNT_W        = 16;
    localparam bit RM_HALT_ON_VIOL = 1'b0;

    typedef enum logic [1:0] {
        RM_IDLE   = 2'd0,
        RM_ACTIVE = 2'd1,
        RM_HALTED = 2'd2
    } rm_state_e;

    // Increment that sticks at the all-ones value of an i_w-bit counter (i_w <= 32).
    function automatic logic [31:0] rm_sat_inc(input logic [31:0] i_val, input int i_w);
        logic [31:0] w_max;
        w_max = (i_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << i_w) - 32'd1);
        return (i_val >= w_max) ? w_max : (i_val + 32'd1);
    endfunction

endpackage

// File: rtl/rm_sat_counter.sv
// rtl/rm_sat_counter.sv - saturating up-counter with synchronous clear
// A clear in the same cycle as an increment yields 1: clear first, then count.
module rm_sat_counter
    import rm_pkg::*;
#(
    parameter int CNT_W = RM_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_base;

    assign w_base = i_clr ? '0 : r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= CNT_W'(rm_sat_inc(32'(w_base), CNT_W));
        end else begin
            r_cnt <= w_base;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ltl_verdict_collector.sv
// rtl/ltl_verdict_collector.sv - per-property verdicts, sticky flags, hit counters, halt FSM and irq
// Optional first-violation timestamp output enabled by RM_VERDICT_TIMESTAMP_EN.
module ltl_verdict_collector
    import rm_pkg::*;
#(
    parameter int NUM_PROPS    = RM_NUM_PROPS,
    parameter int ACC_PER_PROP = RM_ACC_PER_PROP,
    parameter int CNT_W        = RM_CNT_W,
    parameter bit HALT_ON_VIOL = RM_HALT_ON_VIOL,
    localparam int SEL_W       = (NUM_PROPS > 1) ? $clog2(NUM_PROPS) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_run,
    input  logic                              i_hit_valid,
    input  logic [NUM_PROPS*ACC_PER_PROP-1:0] i_hits,
    input  logic                              i_clr,
    input  logic [NUM_PROPS-1:0]              i_clr_mask,
    input  logic [NUM_PROPS-1:0]              i_irq_mask,
    input  logic [SEL_W-1:0]                  i_cnt_sel,
    output logic [NUM_PROPS-1:0]              o_verdict,
    output logic [NUM_PROPS-1:0]              o_sticky,
    output logic                              o_first_valid,
    output logic [SEL_W-1:0]                  o_first_prop,
    output logic [CNT_W-1:0]                  o_sym_cnt,
    output logic [CNT_W-1:0]                  o_cnt_rdata,
    output logic                              o_halted,
    output logic                              o_irq
`ifdef RM_VERDICT_TIMESTAMP_EN
    ,
    output logic [CNT_W-1:0]                  o_first_ts
`endif
);

    rm_state_e            r_state;
    logic                 r_halted;
    logic [NUM_PROPS-1:0] r_verdict;
    logic [NUM_PROPS-1:0] r_sticky;
    logic                 r_first_valid;
    logic [SEL_W-1:0]     r_first_prop;
    logic                 r_irq;
`ifdef RM_VERDICT_TIMESTAMP_EN
    logic [CNT_W-1:0]     r_first_ts;
`endif

    logic                 w_accept;
    logic                 w_clr_all;
    logic                 w_any_verdict;
    logic                 w_capture;
    logic [NUM_PROPS-1:0] w_slice_hit;
    logic [NUM_PROPS-1:0] w_clr_bits;
    logic [SEL_W-1:0]     w_low;
    logic [CNT_W-1:0]     w_sym_cnt;
    logic [CNT_W-1:0]     w_hit_cnt [NUM_PROPS];
    logic [CNT_W-1:0]     w_rdata;

    assign w_accept      = i_hit_valid & i_run & (r_state == RM_ACTIVE);
    assign w_clr_all     = i_clr & (&i_clr_mask);
    assign w_clr_bits    = i_clr ? i_clr_mask : '0;
    assign w_any_verdict = |r_verdict;
    // A clear-all in the capture cycle re-arms the record before the new verdict is taken.
    assign w_capture     = w_any_verdict & (~r_first_valid | w_clr_all);

    for (genvar g = 0; g < NUM_PROPS; g++) begin : g_prop
        assign w_slice_hit[g] = |i_hits[g*ACC_PER_PROP +: ACC_PER_PROP];

        rm_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_inc   (w_accept & w_slice_hit[g]),
            .i_clr   (w_clr_all),
            .o_cnt   (w_hit_cnt[g])
        );
    end

    rm_sat_counter #(.CNT_W(CNT_W)) u_sym_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_accept),
        .i_clr   (w_clr_all),
        .o_cnt   (w_sym_cnt)
    );

    always_comb begin
        w_low = '0;
        for (int p = NUM_PROPS - 1; p >= 0; p--) begin
            if (r_verdict[p]) begin
                w_low = SEL_W'(p);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (int'(i_cnt_sel) < NUM_PROPS) begin
            w_rdata = w_hit_cnt[i_cnt_sel];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= RM_IDLE;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                RM_IDLE: begin
                    if (i_run) begin
                        r_state <= RM_ACTIVE;
                    end
                end
                RM_ACTIVE: begin
                    if (HALT_ON_VIOL && w_any_verdict) begin
                        r_state  <= RM_HALTED;
                        r_halted <= 1'b1;
                    end else if (!i_run) begin
                        r_state <= RM_IDLE;
                    end
                end
                RM_HALTED: begin
                    if (w_clr_all) begin
                        r_state  <= RM_IDLE;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= RM_IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_verdict     <= '0;
            r_sticky      <= '0;
            r_irq         <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_prop  <= '0;
`ifdef RM_VERDICT_TIMESTAMP_EN
            r_first_ts    <= '0;
`endif
        end else begin
            r_verdict <= w_accept ? w_slice_hit : '0;
            // Set from the registered verdict wins over a same-cycle clear.
            r_sticky  <= (r_sticky & ~w_clr_bits) | r_verdict;
            r_irq     <= |(r_sticky & i_irq_mask);
            if (w_capture) begin
                r_first_valid <= 1'b1;
                r_first_prop  <= w_low;
`ifdef RM_VERDICT_TIMESTAMP_EN
                r_first_ts    <= w_sym_cnt;
`endif
            end else if (w_clr_all) begin
                r_first_valid <= 1'b0;
                r_first_prop  <= '0;
`ifdef RM_VERDICT_TIMESTAMP_EN
                r_first_ts    <= '0;
`endif
            end
        end
    end

    assign o_verdict     = r_verdict;
    assign o_sticky      = r_sticky;
    assign o_first_valid = r_first_valid;
    assign o_first_prop  = r_first_prop;
    assign o_sym_cnt     = w_sym_cnt;
    assign o_cnt_rdata   = w_rdata;
    assign o_halted      = r_halted;
    assign o_irq         = r_irq;
`ifdef RM_VERDICT_TIMESTAMP_EN
    assign o_first_ts    = r_first_ts;
`endif

endmodule

// File: tb/tb_ltl_verdict_collector.sv
// tb/tb_ltl_verdict_collector.sv - directed vector bench for ltl_verdict_collector
// Three instances share stimulus: defaults, CNT_W=4, and HALT_ON_VIOL=1.
module tb_ltl_verdict_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        hv;
    logic [15:0] hits;
    logic        clr;
    logic [3:0]  clr_mask;
    logic [3:0]  irq_mask;
    logic [1:0]  sel;

    logic [3:0]  v_a, st_a, v_s, st_s, v_h, st_h;
    logic        fv_a, fv_s, fv_h, hl_a, hl_s, hl_h, irq_a, irq_s, irq_h;
    logic [1:0]  fp_a, fp_s, fp_h;
    logic [15:0] sym_a, rd_a, sym_h, rd_h;
    logic [3:0]  sym_s, rd_s;
`ifdef RM_VERDICT_TIMESTAMP_EN
    logic [15:0] ts_a, ts_h;
    logic [3:0]  ts_s;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ltl_verdict_collector dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_hit_valid(hv), .i_hits(hits),
        .i_clr(clr), .i_clr_mask(clr_mask), .i_irq_mask(irq_mask), .i_cnt_sel(sel),
        .o_verdict(v_a), .o_sticky(st_a), .o_first_valid(fv_a), .o_first_prop(fp_a),
        .o_sym_cnt(sym_a), .o_cnt_rdata(rd_a), .o_halted(hl_a), .o_irq(irq_a)
`ifdef RM_VERDICT_TIMESTAMP_EN
        , .o_first_ts(ts_a)
`endif
    );

    ltl_verdict_collector #(.CNT_W(4)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_hit_valid(hv), .i_hits(hits),
        .i_clr(clr), .i_clr_mask(clr_mask), .i_irq_mask(irq_mask), .i_cnt_sel(sel),
        .o_verdict(v_s), .o_sticky(st_s), .o_first_valid(fv_s), .o_first_prop(fp_s),
        .o_sym_cnt(sym_s), .o_cnt_rdata(rd_s), .o_halted(hl_s), .o_irq(irq_s)
`ifdef RM_VERDICT_TIMESTAMP_EN
        , .o_first_ts(ts_s)
`endif
    );

    ltl_verdict_collector #(.HALT_ON_VIOL(1'b1)) dut_h (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_hit_valid(hv), .i_hits(hits),
        .i_clr(clr), .i_clr_mask(clr_mask), .i_irq_mask(irq_mask), .i_cnt_sel(sel),
        .o_verdict(v_h), .o_sticky(st_h), .o_first_valid(fv_h), .o_first_prop(fp_h),
        .o_sym_cnt(sym_h), .o_cnt_rdata(rd_h), .o_halted(hl_h), .o_irq(irq_h)
`ifdef RM_VERDICT_TIMESTAMP_EN
        , .o_first_ts(ts_h)
`endif
    );

    typedef struct {
        logic        run;
        logic        hv;
        logic [15:0] hits;
        logic        clr;
        logic [3:0]  cmask;
        logic [3:0]  imask;
        logic [1:0]  sel;
        logic [3:0]  e_v;
        logic [3:0]  e_s;
        logic        e_fv;
        logic [1:0]  e_fp;
        logic [15:0] e_sym;
        logic [15:0] e_rd;
        logic        e_irq;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        run = 1'b0; hv = 1'b0; hits = 16'h0; clr = 1'b0;
        clr_mask = 4'h0; irq_mask = 4'h4; sel = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // run hv hits clr cmask imask sel | verdict sticky fv fp sym rdata irq
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h4, 2'd1, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 4'h0, 4'h4, 2'd1, 4'b0010, 4'b0000, 1'b0, 2'd0, 16'd1, 16'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h4, 2'd1, 4'b0000, 4'b0010, 1'b1, 2'd1, 16'd1, 16'd1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'hF, 4'h4, 2'd1, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 16'h1100, 1'b0, 4'h0, 4'h4, 2'd2, 4'b1100, 4'b0000, 1'b0, 2'd0, 16'd1, 16'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 16'h0001, 1'b0, 4'h0, 4'h4, 2'd2, 4'b0001, 4'b1100, 1'b1, 2'd2, 16'd2, 16'd1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h4, 2'd0, 4'b0000, 4'b1101, 1'b1, 2'd2, 16'd2, 16'd1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'h4, 4'h4, 2'd3, 4'b0000, 4'b1001, 1'b1, 2'd2, 16'd2, 16'd1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h4, 2'd3, 4'b0000, 4'b1001, 1'b1, 2'd2, 16'd2, 16'd1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h0100, 1'b0, 4'h0, 4'h4, 2'd2, 4'b0100, 4'b1001, 1'b1, 2'd2, 16'd3, 16'd2, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'h4, 4'h4, 2'd2, 4'b0000, 4'b1101, 1'b1, 2'd2, 16'd3, 16'd2, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h4, 2'd2, 4'b0000, 4'b1101, 1'b1, 2'd2, 16'd3, 16'd2, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 4'h0, 4'h4, 2'd2, 4'b0000, 4'b1101, 1'b1, 2'd2, 16'd3, 16'd2, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 4'h0, 4'h4, 2'd2, 4'b0000, 4'b1101, 1'b1, 2'd2, 16'd3, 16'd2, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 16'h0010, 1'b1, 4'hF, 4'h4, 2'd1, 4'b0010, 4'b0000, 1'b0, 2'd0, 16'd1, 16'd1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h4, 2'd1, 4'b0000, 4'b0010, 1'b1, 2'd1, 16'd1, 16'd1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h4, 2'd2, 4'b0000, 4'b0010, 1'b1, 2'd1, 16'd1, 16'd0, 1'b0};

        // Reset state
        do_reset();
        chk("reset verdict", 32'(v_a), 32'd0);
        chk("reset sticky", 32'(st_a), 32'd0);
        chk("reset first_valid", 32'(fv_a), 32'd0);
        chk("reset first_prop", 32'(fp_a), 32'd0);
        chk("reset sym_cnt", 32'(sym_a), 32'd0);
        chk("reset cnt_rdata", 32'(rd_a), 32'd0);
        chk("reset halted", 32'(hl_a), 32'd0);
        chk("reset irq", 32'(irq_a), 32'd0);

        // Table-driven main sequence on the default instance
        for (int i = 0; i < 17; i++) begin
            run = vecs[i].run; hv = vecs[i].hv; hits = vecs[i].hits; clr = vecs[i].clr;
            clr_mask = vecs[i].cmask; irq_mask = vecs[i].imask; sel = vecs[i].sel;
            step();
            chk($sformatf("v%0d verdict", i), 32'(v_a), 32'(vecs[i].e_v));
            chk($sformatf("v%0d sticky", i), 32'(st_a), 32'(vecs[i].e_s));
            chk($sformatf("v%0d first_valid", i), 32'(fv_a), 32'(vecs[i].e_fv));
            chk($sformatf("v%0d first_prop", i), 32'(fp_a), 32'(vecs[i].e_fp));
            chk($sformatf("v%0d sym_cnt", i), 32'(sym_a), 32'(vecs[i].e_sym));
            chk($sformatf("v%0d cnt_rdata", i), 32'(rd_a), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d irq", i), 32'(irq_a), 32'(vecs[i].e_irq));
        end

        // Saturation with CNT_W=4: 20 symbols all hitting property 0
        do_reset();
        run = 1'b1;
        step();
        hv = 1'b1; hits = 16'h0001;
        repeat (20) step();
        hv = 1'b0; hits = 16'h0; sel = 2'd0;
        step();
        chk("sat sym_cnt", 32'(sym_s), 32'd15);
        chk("sat hit_cnt0", 32'(rd_s), 32'd15);

        // Halt on first violation at symbol 3
        do_reset();
        run = 1'b1;
        step();
        hv = 1'b1; hits = 16'h0000;
        step();
        step();
        hits = 16'h0001;
        step();
        chk("halt verdict pulse", 32'(v_h), 32'd1);
        chk("halt not yet", 32'(hl_h), 32'd0);
        hv = 1'b0; hits = 16'h0;
        step();
        chk("halt halted", 32'(hl_h), 32'd1);
        chk("halt sym_cnt", 32'(sym_h), 32'd3);
        chk("halt first_prop", 32'(fp_h), 32'd0);
        chk("halt first_valid", 32'(fv_h), 32'd1);
`ifdef RM_VERDICT_TIMESTAMP_EN
        chk("halt first_ts", 32'(ts_h), 32'd3);
`endif
        hv = 1'b1; hits = 16'hFFFF; run = 1'b0;
        repeat (3) step();
        chk("halted ignores hits sym", 32'(sym_h), 32'd3);
        chk("halted ignores hits verdict", 32'(v_h), 32'd0);
        chk("halted ignores run", 32'(hl_h), 32'd1);
        hv = 1'b0; hits = 16'h0; run = 1'b1; clr = 1'b1; clr_mask = 4'hF;
        step();
        clr = 1'b0; clr_mask = 4'h0;
        chk("clear-all halted", 32'(hl_h), 32'd0);
        chk("clear-all sym_cnt", 32'(sym_h), 32'd0);
        chk("clear-all first_valid", 32'(fv_h), 32'd0);
`ifdef RM_VERDICT_TIMESTAMP_EN
        chk("clear-all first_ts", 32'(ts_h), 32'd0);
`endif
        step();
        hv = 1'b1;
        step();
        hv = 1'b0;
        chk("reactivated sym_cnt", 32'(sym_h), 32'd1);

        // Asynchronous reset mid-stream
        do_reset();
        run = 1'b1; sel = 2'd1;
        step();
        hv = 1'b1; hits = 16'h0010;
        step();
        hv = 1'b0; hits = 16'h0;
        chk("pre-reset verdict", 32'(v_a), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset verdict", 32'(v_a), 32'd0);
        chk("async reset sym_cnt", 32'(sym_a), 32'd0);
        chk("async reset cnt_rdata", 32'(rd_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0; hv = 1'b1; hits = 16'hFFFF;
        step();
        step();
        chk("idle after reset verdict", 32'(v_a), 32'd0);
        chk("idle after reset sym_cnt", 32'(sym_a), 32'd0);
        chk("idle after reset sticky", 32'(st_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ltl_verdict_collector.md
# ltl_verdict_collector

Parametrised verdict stage for the runtime-monitor (RM) path. It sits behind an automata stage and takes that stage's per-property accepting-state hit vectors. For each property it produces a registered verdict, a sticky violation flag, saturating hit counters and first-violation capture. It also runs an IDLE/ACTIVE/HALTED control FSM with an optional halt-on-first-violation mode and an interrupt.

## Interface
- NUM_PROPS, 4: number of LTL properties monitored (1..32)
- ACC_PER_PROP, 4: accepting-state hit lines per property
- CNT_W, 16: width of symbol-position counter and hit counters
- HALT_ON_VIOL, 0: 1 = enter HALTED on first violation
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  monitor enable; 0 = ignore inputs, hold state
- hit_valid  in  1  hit vector valid for one consumed symbol
- hits  in  NUM_PROPS*ACC_PER_PROP  accepting hits; property p owns bits [p*ACC_PER_PROP +: ACC_PER_PROP]
- clr  in  1  one-cycle clear strobe
- clr_mask  in  NUM_PROPS  sticky flags cleared by clr
- irq_mask  in  NUM_PROPS  properties allowed to raise irq
- cnt_sel  in  $clog2(NUM_PROPS) (min 1)  hit-counter read select
- verdict  out  NUM_PROPS  per-property OR of hits, registered
- sticky  out  NUM_PROPS  latched violation flags
- first_valid  out  1  first-violation record held
- first_prop  out  $clog2(NUM_PROPS) (min 1)  property index of first violation
- sym_cnt  out  CNT_W  symbols accepted since reset/clear-all
- cnt_rdata  out  CNT_W  hit count of property cnt_sel (combinational mux)
- halted  out  1  FSM in HALTED
- irq  out  1  |(sticky & irq_mask), registered

## Operation
- Accept: a symbol is accepted when `hit_valid & run & state==ACTIVE`. No ready signal; non-accepted inputs are dropped.
- On accept:
  - verdict[p] <= |hits[p-slice].
  - sym_cnt increments and saturates at 2^CNT_W-1.
  - hit_cnt[p] increments (saturating) when that slice is nonzero.
- When not accepting, verdict <= 0. verdict is a one-cycle pulse per violating symbol.
- sticky[p] sets when verdict[p] is 1. clr & clr_mask[p] clears it. Set wins over clear in the same cycle.
- First-violation capture:
  - When first_valid==0 and any verdict bit is 1: first_valid <= 1 and first_prop <= lowest set index.
  - The record then holds until a clear-all.
- Clear-all (clr with clr_mask all ones):
  - Zeroes first_valid, first_prop, sym_cnt and all hit_cnt.
  - Also zeroes timestamp storage when configured.
  - Then applies the sticky rule above.
- FSM states:
  - IDLE: run=0 (reset state).
  - IDLE→ACTIVE when run=1.
  - ACTIVE→IDLE when run=0.
  - ACTIVE→HALTED when HALT_ON_VIOL=1 and any verdict bit is 1.
  - HALTED→IDLE on clear-all. HALTED ignores run and hits.
- Reset values: all outputs 0, all counters 0, state IDLE.

## Timing
- Latency: hits accepted at edge N → verdict, hit_cnt and sym_cnt visible after edge N.
- sticky, first_* and halted visible after edge N+1. irq visible after edge N+2.
- Reset mid-operation: asynchronous clear of all state; outputs go to 0 immediately.
- clr in the same cycle as an accept: clear applies first, then the accept is counted. sym_cnt ends at 1 after a clear-all.
- run dropping during HALTED has no effect.
- Saturated counters stay at max until a clear-all.

## Configuration
- RM_VERDICT_TIMESTAMP_EN defined:
  - Adds output first_ts [CNT_W], loaded with the sym_cnt value of the violating symbol (1-based) when first_valid sets.
  - first_ts holds with first_valid and resets to 0.
- RM_VERDICT_TIMESTAMP_EN undefined: no port and no storage.

## Structure
- Shared package rm_pkg holds:
  - FSM state enum (RM_IDLE, RM_ACTIVE, RM_HALTED).
  - Saturating-increment function.
  - Default parameter constants.
- Sub-module rm_sat_counter (CNT_W, inc, clr, saturating) is instantiated NUM_PROPS+1 times (hit counters and sym_cnt).

## Test plan
- Defaults, run=1, hits=16'h0010 for one cycle → verdict=4'b0010 for one cycle; sticky=4'b0010; first_prop=1; sym_cnt=1; cnt_sel=1 gives cnt_rdata=1.
- Same cycle, hits for properties 3 and 2 → first_prop=2. A later hit on property 0 leaves first_prop=2.
- irq_mask=4'b0100, sticky[2] set → irq=1 two edges after the verdict. clr with clr_mask=4'b0100 → sticky=0, irq falls next cycle.
- HALT_ON_VIOL=1, violation on symbol 3 → halted=1, further hits are ignored and sym_cnt stays 3. Clear-all → IDLE, then ACTIVE with run=1. With RM_VERDICT_TIMESTAMP_EN, first_ts=3.
- CNT_W=4, 20 accepted symbols all hitting property 0 → sym_cnt=15 and hit_cnt[0]=15 (saturated).
- reset asserted mid-stream → all outputs 0 asynchronously; after release with run=0, state is IDLE and hits are ignored.
